// File: rtl/exc_ctrl_if.sv
// Bundle between the M-stage pipeline and the exception commit controller:
// the encoded exception record, stall, interrupt lines, the MTC0 write port,
// and the flush/redirect and CP0 register read-back signals.
interface exc_ctrl_if;
   logic [31:0] excepttype;
   logic [31:0] pcM;
   logic        is_in_delayslotM;
   logic [31:0] bad_addrM;
   logic        mem_wrM;
   logic        stallM;
   logic [5:0]  int_i;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic        flush;
   logic        pc_redirect;
   logic [31:0] newpc;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic [31:0] badvaddr_o;

   modport master (
      output excepttype, pcM, is_in_delayslotM, bad_addrM, mem_wrM, stallM,
             int_i, cp0_we, cp0_waddr, cp0_wdata,
      input  flush, pc_redirect, newpc, status_o, cause_o, epc_o, badvaddr_o
   );

   modport slave (
      input  excepttype, pcM, is_in_delayslotM, bad_addrM, mem_wrM, stallM,
             int_i, cp0_we, cp0_waddr, cp0_wdata,
      output flush, pc_redirect, newpc, status_o, cause_o, epc_o, badvaddr_o
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception commit controller at the M stage. Commits an encoded exception
// when M is not stalled (holding it in a latched record while stalled),
// pulses a one-cycle flush with the handler/ERET target, and owns the CP0
// Status, Cause, EPC and BadVAddr registers, which MTC0 may also write.
module exc_ctrl #(
   parameter logic [31:0] REFILL_VEC = 32'hBFC0_0200,
   parameter logic [31:0] GEN_VEC    = 32'hBFC0_0380
) (
   input logic       clk,
   input logic       rst,
   exc_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BLOCK = 2'd2} state_t;

   state_t      state;
   logic        rst_q;
   logic [31:0] rec_type, rec_pc, rec_bad;
   logic        rec_ds, rec_wr;

   logic        exl, ie, bd;
   logic [7:0]  im;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [31:0] epc, badvaddr;

   logic [31:0] sel_type, sel_pc, sel_bad;
   logic        sel_ds, sel_wr;
   logic        live_exc, commit, go_wait, is_eret, save_epc, save_bad;
   logic [31:0] target;

   // Cause.ExcCode for each encoded exception type; unknown types map to RI.
   function automatic logic [4:0] map_code(input logic [31:0] t, input logic wr);
      case (t)
         32'h01:         map_code = 5'h00;
         32'h04:         map_code = 5'h04;
         32'h05:         map_code = 5'h05;
         32'h08:         map_code = 5'h08;
         32'h09:         map_code = 5'h09;
         32'h0a:         map_code = 5'h0a;
         32'h0c:         map_code = 5'h0c;
         32'h10, 32'h11: map_code = 5'h02;
         32'h12, 32'h13: map_code = wr ? 5'h03 : 5'h02;
         32'h14:         map_code = 5'h01;
         default:        map_code = 5'h0a;
      endcase
   endfunction

   // Address errors and TLB faults record the faulting address.
   function automatic logic writes_bad(input logic [31:0] t);
      case (t)
         32'h04, 32'h05, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14: writes_bad = 1'b1;
         default:                                                writes_bad = 1'b0;
      endcase
   endfunction

   // While waiting, the latched record stands in for the live M-stage inputs.
   assign sel_type = (state == WAIT) ? rec_type : bus.excepttype;
   assign sel_pc   = (state == WAIT) ? rec_pc   : bus.pcM;
   assign sel_bad  = (state == WAIT) ? rec_bad  : bus.bad_addrM;
   assign sel_ds   = (state == WAIT) ? rec_ds   : bus.is_in_delayslotM;
   assign sel_wr   = (state == WAIT) ? rec_wr   : bus.mem_wrM;

   // rst_q keeps the cycle right after reset quiet as well.
   assign live_exc = (bus.excepttype != 32'd0);
   assign commit   = !rst && !rst_q && !bus.stallM &&
                     (((state == IDLE) && live_exc) || (state == WAIT));
   assign go_wait  = !rst && !rst_q && bus.stallM && (state == IDLE) && live_exc;
   assign is_eret  = (sel_type == 32'h0e);
   assign save_epc = !exl && !is_eret;
   assign save_bad = writes_bad(sel_type);

   // Handler target: ERET returns to the current EPC, first-level refills use
   // the refill vector, everything else goes to the general vector.
   always_comb begin
      target = GEN_VEC;
      if (is_eret)
         target = epc;
      else if (((sel_type == 32'h10) || (sel_type == 32'h12)) && !exl)
         target = REFILL_VEC;
   end

   assign bus.flush       = commit;
   assign bus.pc_redirect = commit;
   assign bus.newpc       = commit ? target : 32'd0;
   assign bus.status_o    = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
   assign bus.cause_o     = {bd, 15'd0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};
   assign bus.epc_o       = epc;
   assign bus.badvaddr_o  = badvaddr;

   // Capture the exception record when it arrives during a stall.
   always_ff @(posedge clk) begin
      if (go_wait) begin
         rec_type <= bus.excepttype;
         rec_pc   <= bus.pcM;
         rec_bad  <= bus.bad_addrM;
         rec_ds   <= bus.is_in_delayslotM;
         rec_wr   <= bus.mem_wrM;
      end
   end

   // Commit FSM and CP0 registers; commit updates take precedence over MTC0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rst_q    <= 1'b1;
         exl      <= 1'b0;
         ie       <= 1'b0;
         im       <= 8'd0;
         bd       <= 1'b0;
         ip_hw    <= 6'd0;
         ip_sw    <= 2'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
         badvaddr <= 32'd0;
      end else begin
         rst_q <= 1'b0;
         ip_hw <= bus.int_i;

         if (bus.cp0_we) begin
            case (bus.cp0_waddr)
               5'd8:  if (!(commit && save_bad)) badvaddr <= bus.cp0_wdata;
               5'd12: if (!commit) begin
                         im  <= bus.cp0_wdata[15:8];
                         exl <= bus.cp0_wdata[1];
                         ie  <= bus.cp0_wdata[0];
                      end
               5'd13: if (!commit) ip_sw <= bus.cp0_wdata[9:8];
               5'd14: if (!(commit && save_epc)) epc <= bus.cp0_wdata;
               default: ;
            endcase
         end

         if (commit) begin
            exl      <= !is_eret;
            exc_code <= map_code(sel_type, sel_wr);
            if (save_epc) begin
               epc <= sel_ds ? (sel_pc - 32'd4) : sel_pc;
               bd  <= sel_ds;
            end
            if (save_bad)
               badvaddr <= sel_bad;
         end

         case (state)
            IDLE:    if (commit) state <= BLOCK;
                     else if (go_wait) state <= WAIT;
            WAIT:    if (commit) state <= BLOCK;
            BLOCK:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by randomized traffic, all
// compared cycle by cycle against a behavioural model of the CP0 exception
// rules (pending record, post-flush block, register field updates).
module tb_exc_ctrl;

   logic clk;
   logic rst;
   exc_ctrl_if bus ();

   exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit [31:0] t;
      bit [31:0] pc;
      bit [31:0] bad;
      bit        ds;
      bit        wr;
   } rec_t;

   // Model state
   bit        m_exl, m_ie, m_bd, m_pend, m_block, m_rstq;
   bit [7:0]  m_im;
   bit [5:0]  m_iphw;
   bit [1:0]  m_ipsw;
   bit [4:0]  m_code;
   bit [31:0] m_epc, m_bad;
   rec_t      m_rec;

   logic        flush_obs;
   logic [31:0] newpc_obs;
   bit   [31:0] et_tab [14];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [4:0] code_of(input bit [31:0] t, input bit wr);
      if (t == 32'h01) return 5'h00;
      if (t == 32'h04 || t == 32'h05 || t == 32'h08 || t == 32'h09 ||
          t == 32'h0a || t == 32'h0c) return t[4:0];
      if (t == 32'h10 || t == 32'h11) return 5'h02;
      if (t == 32'h12 || t == 32'h13) return wr ? 5'h03 : 5'h02;
      if (t == 32'h14) return 5'h01;
      return 5'h0a;
   endfunction

   function automatic bit has_bad(input bit [31:0] t);
      return (t == 32'h04 || t == 32'h05 || (t >= 32'h10 && t <= 32'h14));
   endfunction

   function automatic bit [31:0] exp_status();
      return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
   endfunction

   function automatic bit [31:0] exp_cause();
      return (32'(m_bd) << 31) | (32'(m_iphw) << 10) | (32'(m_ipsw) << 8) | (32'(m_code) << 2);
   endfunction

   task automatic set_in(input bit [31:0] t, input bit [31:0] pc, input bit ds,
                         input bit [31:0] bad, input bit wr, input bit stall);
      bus.excepttype       = t;
      bus.pcM              = pc;
      bus.is_in_delayslotM = ds;
      bus.bad_addrM        = bad;
      bus.mem_wrM          = wr;
      bus.stallM           = stall;
   endtask

   // One clock cycle: check the combinational outputs, clock, update the
   // model, then check the CP0 registers. Entered and left at a falling edge.
   task automatic step();
      rec_t      cur;
      bit        commit, latch, epc_hit, bad_hit;
      bit [31:0] exp_pc;
      cur.t = bus.excepttype; cur.pc = bus.pcM; cur.bad = bus.bad_addrM;
      cur.ds = bus.is_in_delayslotM; cur.wr = bus.mem_wrM;
      commit = 1'b0;
      latch  = 1'b0;
      if (!rst && !m_rstq && !m_block) begin
         if (m_pend) begin
            if (!bus.stallM) begin commit = 1'b1; cur = m_rec; end
         end else if (cur.t != 0) begin
            if (bus.stallM) latch = 1'b1;
            else            commit = 1'b1;
         end
      end
      exp_pc = 32'd0;
      if (commit) begin
         if (cur.t == 32'h0e)                                      exp_pc = m_epc;
         else if ((cur.t == 32'h10 || cur.t == 32'h12) && !m_exl)  exp_pc = 32'hBFC0_0200;
         else                                                      exp_pc = 32'hBFC0_0380;
      end
      #1;
      flush_obs = bus.flush;
      newpc_obs = bus.newpc;
      check("flush", {31'd0, bus.flush}, {31'd0, commit});
      check("pc_redirect", {31'd0, bus.pc_redirect}, {31'd0, commit});
      check("newpc", bus.newpc, exp_pc);
      @(posedge clk);
      if (rst) begin
         m_exl = 0; m_ie = 0; m_im = 0; m_bd = 0; m_iphw = 0; m_ipsw = 0;
         m_code = 0; m_epc = 0; m_bad = 0;
         m_pend = 0; m_block = 0; m_rstq = 1;
      end else begin
         epc_hit = commit && !m_exl && cur.t != 32'h0e;
         bad_hit = commit && has_bad(cur.t);
         m_rstq = 0;
         m_iphw = bus.int_i;
         if (bus.cp0_we) begin
            if (bus.cp0_waddr == 5'd8 && !bad_hit) m_bad = bus.cp0_wdata;
            if (bus.cp0_waddr == 5'd12 && !commit) begin
               m_im = bus.cp0_wdata[15:8]; m_exl = bus.cp0_wdata[1]; m_ie = bus.cp0_wdata[0];
            end
            if (bus.cp0_waddr == 5'd13 && !commit) m_ipsw = bus.cp0_wdata[9:8];
            if (bus.cp0_waddr == 5'd14 && !epc_hit) m_epc = bus.cp0_wdata;
         end
         if (commit) begin
            if (epc_hit) begin
               m_epc = cur.ds ? cur.pc - 32'd4 : cur.pc;
               m_bd  = cur.ds;
            end
            if (bad_hit) m_bad = cur.bad;
            m_code = code_of(cur.t, cur.wr);
            m_exl  = (cur.t != 32'h0e);
            m_pend = 0;
         end
         if (latch) begin m_pend = 1; m_rec = cur; end
         m_block = commit;
      end
      #1;
      check("status", bus.status_o, exp_status());
      check("cause", bus.cause_o, exp_cause());
      check("epc", bus.epc_o, m_epc);
      check("badvaddr", bus.badvaddr_o, m_bad);
      @(negedge clk);
   endtask

   task automatic mtc(input bit [4:0] addr, input bit [31:0] data);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      bus.cp0_we = 1'b1; bus.cp0_waddr = addr; bus.cp0_wdata = data;
      step();
      bus.cp0_we = 1'b0;
   endtask

   initial begin
      et_tab = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c,
                 32'h0e, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h07};
      rst = 1'b1;
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      bus.int_i = 6'd0; bus.cp0_we = 1'b0; bus.cp0_waddr = 5'd0; bus.cp0_wdata = 32'd0;
      @(negedge clk);
      step();
      step();
      check("rst_status", bus.status_o, 32'h0040_0000);
      check("rst_cause", bus.cause_o, 32'd0);
      check("rst_epc", bus.epc_o, 32'd0);
      check("rst_bad", bus.badvaddr_o, 32'd0);
      rst = 1'b0;
      step();
      step();

      // Syscall without stall
      set_in(32'h08, 32'hBFC0_1000, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      check("sys_flush", {31'd0, flush_obs}, 32'd1);
      check("sys_newpc", newpc_obs, 32'hBFC0_0380);
      check("sys_epc", bus.epc_o, 32'hBFC0_1000);
      check("sys_code", {27'd0, bus.cause_o[6:2]}, 32'h08);
      check("sys_exl", {31'd0, bus.status_o[1]}, 32'd1);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // Delay-slot address error on load
      mtc(5'd12, 32'd0);
      set_in(32'h04, 32'hBFC0_2004, 1'b1, 32'h1234_5671, 1'b0, 1'b0);
      step();
      check("ds_epc", bus.epc_o, 32'hBFC0_2000);
      check("ds_bd", {31'd0, bus.cause_o[31]}, 32'd1);
      check("ds_bad", bus.badvaddr_o, 32'h1234_5671);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // Stall hold with inputs changing underneath the latched record
      mtc(5'd12, 32'd0);
      set_in(32'h0c, 32'hBFC0_7000, 1'b0, 32'd0, 1'b0, 1'b1);
      step();
      check("hold_c1", {31'd0, flush_obs}, 32'd0);
      set_in(32'h08, 32'h1111_1110, 1'b1, 32'h0, 1'b0, 1'b1);
      step();
      check("hold_c2", {31'd0, flush_obs}, 32'd0);
      step();
      check("hold_c3", {31'd0, flush_obs}, 32'd0);
      set_in(32'h04, 32'hBFC0_8888, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0);
      step();
      check("hold_flush", {31'd0, flush_obs}, 32'd1);
      check("hold_newpc", newpc_obs, 32'hBFC0_0380);
      check("hold_epc", bus.epc_o, 32'hBFC0_7000);
      check("hold_code", {27'd0, bus.cause_o[6:2]}, 32'h0c);
      check("hold_bad", bus.badvaddr_o, 32'h1234_5671);
      set_in(32'h08, 32'hBFC0_9000, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      check("hold_block", {31'd0, flush_obs}, 32'd0);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // Refill versus nested TLB miss
      mtc(5'd12, 32'd0);
      set_in(32'h10, 32'hBFC0_5000, 1'b0, 32'h0000_4000, 1'b0, 1'b0);
      step();
      check("refill_newpc", newpc_obs, 32'hBFC0_0200);
      check("refill_epc", bus.epc_o, 32'hBFC0_5000);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      set_in(32'h10, 32'hBFC0_6000, 1'b0, 32'h0000_5000, 1'b0, 1'b0);
      step();
      check("nested_newpc", newpc_obs, 32'hBFC0_0380);
      check("nested_epc", bus.epc_o, 32'hBFC0_5000);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // ERET
      mtc(5'd14, 32'hBFC0_3000);
      set_in(32'h0e, 32'hBFC0_0400, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      check("eret_newpc", newpc_obs, 32'hBFC0_3000);
      check("eret_exl", {31'd0, bus.status_o[1]}, 32'd0);
      check("eret_epc", bus.epc_o, 32'hBFC0_3000);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // Reset while waiting discards the latched record
      set_in(32'h0c, 32'hBFC0_A000, 1'b0, 32'd0, 1'b0, 1'b1);
      step();
      rst = 1'b1;
      set_in(32'h0c, 32'hBFC0_A000, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      check("rstw_flush0", {31'd0, flush_obs}, 32'd0);
      rst = 1'b0;
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      check("rstw_flush1", {31'd0, flush_obs}, 32'd0);
      check("rstw_status", bus.status_o, 32'h0040_0000);
      step();
      check("rstw_flush2", {31'd0, flush_obs}, 32'd0);

      // MTC0 to EPC colliding with a commit
      set_in(32'h08, 32'hBFC0_4000, 1'b0, 32'd0, 1'b0, 1'b0);
      bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
      step();
      bus.cp0_we = 1'b0;
      check("coll_epc", bus.epc_o, 32'hBFC0_4000);
      set_in(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();

      // Hardware interrupt sampling
      bus.int_i = 6'h2A;
      step();
      check("int_ip", {26'd0, bus.cause_o[15:10]}, 32'h2A);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 21);
         set_in((r < 8) ? 32'd0 : et_tab[r - 8], $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 35);
         bus.int_i     = 6'($urandom);
         bus.cp0_we    = $urandom_range(0, 99) < 20;
         r = $urandom_range(0, 4);
         bus.cp0_waddr = (r == 0) ? 5'd8 : (r == 1) ? 5'd12 : (r == 2) ? 5'd13 :
                         (r == 3) ? 5'd14 : 5'd2;
         bus.cp0_wdata = $urandom;
         rst = $urandom_range(0, 99) < 2;
         step();
      end
      rst = 1'b0;
      bus.cp0_we = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
